// File: rtl/crc_seq_ctrl_if.sv
// rtl/crc_seq_ctrl_if.sv - requester and response bus for crc_seq_ctrl
//
// Purpose: groups the two requester job handshakes and the result handshake.
//   master : the side issuing jobs and consuming results (requesters)
//   slave  : the sequencer (crc_seq_ctrl)
// Signals:
//   reqN_valid/reqN_ready  job handshake for requester N (N=0,1)
//   reqN_data              job word, shifted MSB-first
//   reqN_mode              00 CRC8, 01 CRC16, 10 CRC32, 11 illegal
//   reqN_poly              generator polynomial (implicit top bit)
//   reqN_first/reqN_last   restart CRC / return result after this word
//   rsp_valid/rsp_ready    result handshake
//   rsp_id/rsp_crc/rsp_err requester, result, illegal-mode flag
interface crc_seq_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_data;
   logic [1:0]        req0_mode;
   logic [31:0]       req0_poly;
   logic              req0_first;
   logic              req0_last;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_data;
   logic [1:0]        req1_mode;
   logic [31:0]       req1_poly;
   logic              req1_first;
   logic              req1_last;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [31:0]       rsp_crc;
   logic              rsp_err;

   modport master (
      output req0_valid, req0_data, req0_mode, req0_poly, req0_first, req0_last,
      input  req0_ready,
      output req1_valid, req1_data, req1_mode, req1_poly, req1_first, req1_last,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_crc, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_data, req0_mode, req0_poly, req0_first, req0_last,
      output req0_ready,
      input  req1_valid, req1_data, req1_mode, req1_poly, req1_first, req1_last,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_crc, rsp_err,
      input  rsp_ready
   );
endinterface

// File: rtl/crc_seq_ctrl.sv
// rtl/crc_seq_ctrl.sv - two-requester job sequencer for a bit-serial CRC engine
//
// Purpose: arbitrates jobs from two requesters (round-robin, with a lock that
// keeps a multi-word job on one requester), shifts each job word MSB-first
// into an external serial_crc engine and returns the masked result.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   bus (slave)         requester job handshakes and result handshake
//   crc_data_in         serial data bit to the engine
//   crc_data_valid      engine shift enable
//   crc_init            one-cycle engine restart
//   crc_mode            CRC width select held from the last accepted job
//   crc_polynomial      polynomial held from the last accepted job
//   crc_out             engine remainder
// Configuration macro: CRC_FINAL_XOR_EN - XOR the result with the mode mask.
module crc_seq_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   crc_seq_ctrl_if.slave        bus,
   output logic                 crc_data_in,
   output logic                 crc_data_valid,
   output logic                 crc_init,
   output logic [1:0]           crc_mode,
   output logic [31:0]          crc_polynomial,
   input  logic [31:0]          crc_out
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHIFT,
      ST_DRAIN,
      ST_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        mode_q, mode_d;
   logic [31:0]       poly_q, poly_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic              lock_q, lock_d;
   logic              rr_q, rr_d;
   logic              started_q, started_d;
   logic [31:0]       res_q, res_d;
   logic              err_q, err_d;

   logic              gnt_vld;
   logic              gnt_id;
   logic              accept;
   logic [DATA_W-1:0] sel_data;
   logic [1:0]        sel_mode;
   logic [31:0]       sel_poly;
   logic              sel_first;
   logic              sel_last;
   logic [31:0]       mask;
   logic [31:0]       res_final;

   function automatic logic [31:0] mode_mask(input logic [1:0] m);
      case (m)
         2'b00:   mode_mask = 32'h0000_00FF;
         2'b01:   mode_mask = 32'h0000_FFFF;
         default: mode_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

   // While locked only the lock owner may be granted; otherwise rr_q names
   // the requester that wins a tie (the one not served last).
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = rr_q;
      if (lock_q) begin
         gnt_id  = id_q;
         gnt_vld = id_q ? bus.req1_valid : bus.req0_valid;
      end else if (bus.req0_valid && bus.req1_valid) begin
         gnt_id  = rr_q;
         gnt_vld = 1'b1;
      end else if (bus.req0_valid) begin
         gnt_id  = 1'b0;
         gnt_vld = 1'b1;
      end else if (bus.req1_valid) begin
         gnt_id  = 1'b1;
         gnt_vld = 1'b1;
      end
   end

   // Ready is gated by rst_n so it is low throughout reset even if a
   // requester holds valid.
   assign accept         = rst_n && (state_q == ST_IDLE) && gnt_vld;
   assign bus.req0_ready = accept && !gnt_id;
   assign bus.req1_ready = accept && gnt_id;

   assign sel_data  = gnt_id ? bus.req1_data  : bus.req0_data;
   assign sel_mode  = gnt_id ? bus.req1_mode  : bus.req0_mode;
   assign sel_poly  = gnt_id ? bus.req1_poly  : bus.req0_poly;
   assign sel_first = gnt_id ? bus.req1_first : bus.req0_first;
   assign sel_last  = gnt_id ? bus.req1_last  : bus.req0_last;

   assign mask = mode_mask(mode_q);

`ifdef CRC_FINAL_XOR_EN
   assign res_final = (crc_out & mask) ^ mask;
`else
   assign res_final = crc_out & mask;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      mode_d    = mode_q;
      poly_d    = poly_q;
      last_d    = last_q;
      id_d      = id_q;
      lock_d    = lock_q;
      rr_d      = rr_q;
      started_d = started_q;
      res_d     = res_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               data_d    = sel_data;
               mode_d    = sel_mode;
               poly_d    = sel_poly;
               last_d    = sel_last;
               id_d      = gnt_id;
               rr_d      = ~gnt_id;
               started_d = 1'b1;
               cnt_d     = '0;
               err_d     = 1'b0;
               if (sel_mode == 2'b11) begin
                  // Illegal mode: no engine activity, report the error.
                  err_d   = 1'b1;
                  res_d   = '0;
                  state_d = ST_RESP;
               end else if (sel_first || !started_q) begin
                  // The engine state is unknown after reset, so the very
                  // first job always restarts it.
                  state_d = ST_INIT;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_INIT: begin
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_MAX) begin
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // The engine registers the last bit on the final shift edge,
            // so crc_out is complete during this cycle.
            res_d = res_final;
            if (last_q) begin
               state_d = ST_RESP;
            end else begin
               lock_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               lock_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         mode_q    <= '0;
         poly_q    <= '0;
         last_q    <= 1'b0;
         id_q      <= 1'b0;
         lock_q    <= 1'b0;
         rr_q      <= 1'b0;
         started_q <= 1'b0;
         res_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         mode_q    <= mode_d;
         poly_q    <= poly_d;
         last_q    <= last_d;
         id_q      <= id_d;
         lock_q    <= lock_d;
         rr_q      <= rr_d;
         started_q <= started_d;
         res_q     <= res_d;
         err_q     <= err_d;
      end
   end

   assign crc_init       = (state_q == ST_INIT);
   assign crc_data_valid = (state_q == ST_SHIFT);
   assign crc_data_in    = (state_q == ST_SHIFT) && data_q[CNT_MAX - cnt_q];
   assign crc_mode       = mode_q;
   assign crc_polynomial = poly_q;

   assign bus.rsp_valid  = (state_q == ST_RESP);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_crc    = res_q;
   assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_crc_seq_ctrl.sv
// tb/tb_crc_seq_ctrl.sv - self-checking bench for crc_seq_ctrl
module tb_crc_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        crc_data_in, crc_data_valid, crc_init;
   logic [1:0]  crc_mode;
   logic [31:0] crc_polynomial, crc_out;

   int n_pass = 0, n_total = 0;

   crc_seq_ctrl_if #(.DATA_W(32)) bus ();

   crc_seq_ctrl #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .crc_data_in(crc_data_in), .crc_data_valid(crc_data_valid),
      .crc_init(crc_init), .crc_mode(crc_mode),
      .crc_polynomial(crc_polynomial), .crc_out(crc_out)
   );

   always #5 clk = ~clk;

   function automatic int width(input logic [1:0] m);
      return (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
   endfunction

   function automatic logic [31:0] mmask(input logic [1:0] m);
      return (m == 2'b00) ? 32'hFF : (m == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
   endfunction

   // Stand-in for serial_crc: MSB-first LFSR, cleared by crc_init.
   function automatic logic [31:0] eng_step(input logic [31:0] r, input logic din,
                                            input logic [1:0] m, input logic [31:0] p);
      logic fb;
      fb = r[width(m)-1] ^ din;
      r  = (r << 1) & mmask(m);
      if (fb) r = r ^ (p & mmask(m));
      return r;
   endfunction

   logic [31:0] eng_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              eng_q <= '0;
      else if (crc_init)       eng_q <= '0;
      else if (crc_data_valid) eng_q <= eng_step(eng_q, crc_data_in, crc_mode, crc_polynomial);
   end
   assign crc_out = eng_q;

   // Reference: remainder (S*x^32 + D*x^w) mod G by polynomial long division.
   function automatic logic [31:0] ref_crc(input logic [31:0] s, input logic [31:0] d,
                                           input logic [1:0] m, input logic [31:0] p);
      logic [95:0] v, g;
      int w;
      w = width(m);
      v = ({64'd0, s} << 32) ^ ({64'd0, d} << w);
      g = {64'd0, p & mmask(m)} | (96'd1 << w);
      for (int i = 95; i >= w; i--)
         if (v[i]) v = v ^ (g << (i - w));
      return v[31:0] & mmask(m);
   endfunction

   function automatic logic [31:0] exp_rsp(input logic [31:0] s, input logic [1:0] m);
      logic [31:0] r;
      if (m == 2'b11) return 32'd0;
      r = s & mmask(m);
`ifdef CRC_FINAL_XOR_EN
      r = r ^ mmask(m);
`endif
      return r;
   endfunction

   // Monitor: free-running counters; tests take snapshots and diff them.
   int n_init = 0, n_dv = 0, n_rsp = 0, cyc = 0;
   int acc0_cyc = -1, rsp1_cyc = -1, init_at_rsp1 = -1;
   always @(negedge clk) begin
      cyc++;
      if (crc_init) n_init++;
      if (crc_data_valid) n_dv++;
      if (bus.req0_valid && bus.req0_ready) acc0_cyc = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
         n_rsp++;
         if (bus.rsp_id) begin
            rsp1_cyc     = cyc;
            init_at_rsp1 = n_init;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic set_req(input bit id, input bit v, input logic [31:0] d, input logic [1:0] m,
                          input logic [31:0] p, input bit f, input bit l);
      if (id) begin
         bus.req1_valid = v; bus.req1_data = d; bus.req1_mode = m;
         bus.req1_poly = p; bus.req1_first = f; bus.req1_last = l;
      end else begin
         bus.req0_valid = v; bus.req0_data = d; bus.req0_mode = m;
         bus.req0_poly = p; bus.req0_first = f; bus.req0_last = l;
      end
   endtask

   task automatic drop_valid(input bit id);
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic drive(input bit id, input logic [31:0] d, input logic [1:0] m,
                        input logic [31:0] p, input bit f, input bit l);
      bit done = 0;
      set_req(id, 1'b1, d, m, p, f, l);
      for (int i = 0; i < 300 && !done; i++) begin
         #1;
         if (id ? bus.req1_ready : bus.req0_ready) begin
            @(posedge clk);
            done = 1;
         end
         @(negedge clk);
      end
      drop_valid(id);
      if (!done) chk("accept_timeout", 96'(done), 96'd1);
   endtask

   task automatic wait_rsp(input string name, input bit id, input logic [31:0] crc, input bit err);
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (bus.rsp_valid) seen = 1;
         else @(negedge clk);
      end
      chk({name, "_rsp_seen"}, 96'(seen), 96'd1);
      if (seen) begin
         chk({name, "_rsp_id"}, 96'(bus.rsp_id), 96'(id));
         chk({name, "_rsp_crc"}, 96'(bus.rsp_crc), 96'(crc));
         chk({name, "_rsp_err"}, 96'(bus.rsp_err), 96'(err));
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [95:0] all_outs();
      return 96'({crc_init, crc_data_valid, crc_data_in, crc_mode, crc_polynomial,
                  bus.rsp_valid, bus.rsp_id, bus.rsp_crc, bus.rsp_err,
                  bus.req0_ready, bus.req1_ready});
   endfunction

   typedef struct {
      bit          id;
      logic [31:0] data;
      logic [1:0]  mode;
      logic [31:0] poly;
      bit          exp_err;
   } vec_t;

   initial begin
      vec_t        vecs[6];
      logic [31:0] cap, s, r0;
      logic [1:0]  m;
      logic [31:0] p;
      bit          dv_all, init_any, stable, id;
      int          base, base2, nw;

      vecs[0] = '{0, 32'hDEAD_BEEF, 2'b10, 32'h04C1_1DB7, 0};
      vecs[1] = '{1, 32'h0000_0001, 2'b00, 32'h0000_0007, 0};
      vecs[2] = '{0, 32'h8000_0000, 2'b01, 32'h0000_1021, 0};
      vecs[3] = '{1, 32'hFFFF_FFFF, 2'b01, 32'h0000_8005, 0};
      vecs[4] = '{1, 32'h1234_5678, 2'b11, 32'h0000_1021, 1};
      vecs[5] = '{0, 32'hCAFE_F00D, 2'b00, 32'h0000_0031, 0};

      bus.rsp_ready = 1'b1;
      set_req(0, 1, 32'h1, 2'b10, 32'h1, 1, 1);
      set_req(1, 1, 32'h1, 2'b10, 32'h1, 1, 1);
      #12;
      chk("reset_outputs", all_outs(), 96'd0);
      do_reset();

      // Latency and bit order of a single CRC32 word.
      set_req(0, 1, 32'h0123_4567, 2'b10, 32'h04C1_1DB7, 1, 1);
      #1;
      chk("lat_ready0", 96'(bus.req0_ready), 96'd1);
      @(posedge clk); @(negedge clk);
      drop_valid(0);
      chk("lat_init_c1", 96'(crc_init), 96'd1);
      cap = '0; dv_all = 1; init_any = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         cap[31-k] = crc_data_in;
         dv_all    = dv_all & crc_data_valid;
         init_any  = init_any | crc_init;
      end
      chk("lat_shift_bits", 96'(cap), 96'h0123_4567);
      chk("lat_shift_dv", 96'({dv_all, init_any}), 96'b10);
      @(negedge clk);
      chk("lat_drain", 96'({crc_data_valid, bus.rsp_valid}), 96'd0);
      @(negedge clk);
      chk("lat_rsp_c35", 96'(bus.rsp_valid), 96'd1);
      chk("lat_rsp_crc", 96'(bus.rsp_crc),
          96'(exp_rsp(ref_crc(0, 32'h0123_4567, 2'b10, 32'h04C1_1DB7), 2'b10)));
      @(posedge clk); @(negedge clk);

      // Simultaneous requests from reset: req0 first.
      do_reset();
      fork
         drive(0, 32'hA1A2_A3A4, 2'b10, 32'h04C1_1DB7, 1, 1);
         drive(1, 32'hB1B2_B3B4, 2'b01, 32'h0000_1021, 1, 1);
         begin
            wait_rsp("rr0", 0, exp_rsp(ref_crc(0, 32'hA1A2_A3A4, 2'b10, 32'h04C1_1DB7), 2'b10), 0);
            wait_rsp("rr1", 1, exp_rsp(ref_crc(0, 32'hB1B2_B3B4, 2'b01, 32'h0000_1021), 2'b01), 0);
         end
      join

      // Locked two-word job on req1 while req0 waits.
      do_reset();
      base = n_init;
      s = ref_crc(ref_crc(0, 32'h1122_3344, 2'b10, 32'h04C1_1DB7), 32'h5566_7788, 2'b10, 32'h04C1_1DB7);
      fork
         begin
            drive(1, 32'h1122_3344, 2'b10, 32'h04C1_1DB7, 1, 0);
            drive(1, 32'h5566_7788, 2'b10, 32'h04C1_1DB7, 0, 1);
            wait_rsp("lock1", 1, exp_rsp(s, 2'b10), 0);
         end
         begin
            repeat (2) @(negedge clk);
            drive(0, 32'h0BAD_CAFE, 2'b01, 32'h0000_8005, 1, 1);
            wait_rsp("lock0", 0, exp_rsp(ref_crc(0, 32'h0BAD_CAFE, 2'b01, 32'h0000_8005), 2'b01), 0);
         end
      join
      chk("lock_req0_after_rsp1", 96'(acc0_cyc > rsp1_cyc && rsp1_cyc > 0), 96'd1);
      chk("lock_one_init", 96'(init_at_rsp1 - base), 96'd1);

      // Illegal mode; then confirm an illegal word clears a held lock.
      base = n_dv;
      drive(0, 32'h1357_9BDF, 2'b11, 32'h04C1_1DB7, 1, 1);
      wait_rsp("ill", 0, 32'd0, 1);
      chk("ill_no_dv", 96'(n_dv - base), 96'd0);
      drive(1, 32'h2468_ACE0, 2'b10, 32'h04C1_1DB7, 1, 0);
      drive(1, 32'h2468_ACE0, 2'b11, 32'h04C1_1DB7, 0, 1);
      wait_rsp("ill_lock", 1, 32'd0, 1);
      drive(0, 32'h0F0F_0F0F, 2'b00, 32'h0000_0007, 1, 1);
      wait_rsp("ill_unlock", 0, exp_rsp(ref_crc(0, 32'h0F0F_0F0F, 2'b00, 32'h07), 2'b00), 0);

      // Back-pressure on the response.
      bus.rsp_ready = 1'b0;
      drive(1, 32'hA5C3_0F96, 2'b00, 32'h0000_0007, 1, 1);
      for (int i = 0; i < 60 && !bus.rsp_valid; i++) @(negedge clk);
      r0 = bus.rsp_crc;
      stable = bus.rsp_valid;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         stable = stable & bus.rsp_valid & (bus.rsp_crc == r0) & bus.rsp_id;
      end
      chk("bp_stable", 96'(stable), 96'd1);
      chk("bp_upper_zero", 96'(bus.rsp_crc[31:8]), 96'd0);
      bus.rsp_ready = 1'b1;
      wait_rsp("bp", 1, exp_rsp(ref_crc(0, 32'hA5C3_0F96, 2'b00, 32'h07), 2'b00), 0);

      // Reset at shift cycle 10 aborts silently; next job restarts the CRC.
      set_req(0, 1, 32'h7777_1111, 2'b10, 32'h04C1_1DB7, 1, 1);
      @(posedge clk); @(negedge clk);
      drop_valid(0);
      repeat (11) @(negedge clk);
      base = n_rsp;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", all_outs(), 96'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_no_rsp", 96'(n_rsp - base), 96'd0);
      base2 = n_init;
      drive(1, 32'h3C3C_5A5A, 2'b01, 32'h0000_1021, 0, 1);
      wait_rsp("rst_next", 1, exp_rsp(ref_crc(0, 32'h3C3C_5A5A, 2'b01, 32'h1021), 2'b01), 0);
      chk("rst_next_init", 96'(n_init - base2), 96'd1);

      // Table-driven single-word jobs.
      foreach (vecs[i]) begin
         drive(vecs[i].id, vecs[i].data, vecs[i].mode, vecs[i].poly, 1, 1);
         wait_rsp($sformatf("vec%0d", i), vecs[i].id,
                  vecs[i].exp_err ? 32'd0 : exp_rsp(ref_crc(0, vecs[i].data, vecs[i].mode, vecs[i].poly), vecs[i].mode),
                  vecs[i].exp_err);
      end

      // Random chains of 1..3 words from one requester.
      for (int c = 0; c < 16; c++) begin
         id = 1'($urandom_range(0, 1));
         m  = 2'($urandom_range(0, 3));
         p  = $urandom;
         nw = (m == 2'b11) ? 1 : $urandom_range(1, 3);
         s  = '0;
         for (int w = 0; w < nw; w++) begin
            cap = $urandom;
            drive(id, cap, m, p, w == 0, w == nw - 1);
            if (m != 2'b11) s = ref_crc(s, cap, m, p);
         end
         wait_rsp($sformatf("rnd%0d", c), id, exp_rsp(s, m), m == 2'b11);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
